mpmc10_wrreq_fifo: RTL and testbench



---
 rtl/mpmc10_wrreq_fifo_if.sv | 42 ++++
 rtl/mpmc10_wrreq_fifo.sv | 61 ++++++
 tb/tb_mpmc10_wrreq_fifo.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/mpmc10_wrreq_fifo_if.sv
// Write-request type shared by the mpmc10 write path, and the bundle
// connecting a channel port to the write-request FIFO.
package mpmc10_wrreq_pkg;
  typedef struct packed {
    logic [7:0]   tid;
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    logic [31:0]  adr;
    logic [127:0] dat;
  } wb_write_request128_t;
endpackage

// Handshake: an entry is pushed on a rising edge when wr is high and the FIFO
// is not full (or a pop is accepted on that same edge); an entry is popped
// when rd is high and empty is low. o always holds the head entry, or zero.
interface mpmc10_wrreq_fifo_if #(
  parameter int DEPTH = 16
);
  import mpmc10_wrreq_pkg::*;

  logic                     wr;
  wb_write_request128_t     i;
  logic                     rd;
  wb_write_request128_t     o;
  logic                     empty;
  logic                     full;
  logic                     almost_full;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport master (
    output wr, i, rd,
    input  o, empty, full, almost_full, count, overflow
  );

  modport slave (
    input  wr, i, rd,
    output o, empty, full, almost_full, count, overflow
  );
endinterface

// File: rtl/mpmc10_wrreq_fifo.sv
// First-word-fall-through FIFO for 128-bit Wishbone write requests, feeding
// the mpmc10 write-request sync register.
module mpmc10_wrreq_fifo #(
  parameter int DEPTH = 16,
  parameter int AFULL = 12
) (
  input  logic                clk,
  input  logic                rst,
  mpmc10_wrreq_fifo_if.slave  bus
);
  import mpmc10_wrreq_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL);

  wb_write_request128_t mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          ovf;

  logic is_empty;
  logic is_full;
  logic push_ok;
  logic pop_ok;

  assign is_empty = (cnt == '0);
  assign is_full  = (cnt == DEPTH_C);
  assign pop_ok   = bus.rd && !is_empty;
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok  = bus.wr && (!is_full || pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wptr] <= bus.i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      ovf  <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop_ok)  rptr <= rptr + 1'b1;
      if (push_ok && !pop_ok)      cnt <= cnt + 1'b1;
      else if (pop_ok && !push_ok) cnt <= cnt - 1'b1;
      if (bus.wr && !push_ok) ovf <= 1'b1;
    end
  end

  // Storage is not cleared on reset, so the head is masked while empty.
  assign bus.o           = is_empty ? '0 : mem[rptr];
  assign bus.empty       = is_empty;
  assign bus.full        = is_full;
  assign bus.almost_full = (cnt >= AFULL_C);
  assign bus.count       = cnt;
  assign bus.overflow    = ovf;
endmodule

// File: tb/tb_mpmc10_wrreq_fifo.sv
// Directed and short random checks of mpmc10_wrreq_fifo against a queue model.
module tb_mpmc10_wrreq_fifo;
  import mpmc10_wrreq_pkg::*;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;
  localparam int W     = $bits(wb_write_request128_t);

  logic clk;
  logic rst;

  mpmc10_wrreq_fifo_if #(.DEPTH(DEPTH)) bus ();

  mpmc10_wrreq_fifo #(.DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // model: contents in arrival order plus the sticky drop flag
  logic [W-1:0] exp_q[$];
  logic         exp_ovf = 1'b0;
  logic         chk_en  = 1'b0;

  always @(posedge clk) begin
    logic pop_acc;
    logic push_acc;
    if (rst) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      pop_acc  = bus.rd && (exp_q.size() > 0);
      push_acc = bus.wr && ((exp_q.size() < DEPTH) || pop_acc);
      if (pop_acc) void'(exp_q.pop_front());
      if (push_acc) exp_q.push_back(W'(bus.i));
      if (bus.wr && !push_acc) exp_ovf = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard compare, every cycle once reset has been applied
  always @(negedge clk) begin
    logic [W-1:0] head;
    if (chk_en) begin
      head = (exp_q.size() == 0) ? '0 : exp_q[0];
      chk("model_o",        W'(bus.o),           head);
      chk("model_count",    W'(bus.count),       W'(exp_q.size()));
      chk("model_empty",    W'(bus.empty),       W'(exp_q.size() == 0));
      chk("model_full",     W'(bus.full),        W'(exp_q.size() == DEPTH));
      chk("model_afull",    W'(bus.almost_full), W'(exp_q.size() >= AFULL));
      chk("model_overflow", W'(bus.overflow),    W'(exp_ovf));
    end
  end

  function automatic wb_write_request128_t mk_req(input logic [31:0] a);
    wb_write_request128_t r;
    r.tid = a[7:0] ^ 8'h5A;
    r.cyc = 1'b1;
    r.stb = 1'b1;
    r.we  = 1'b1;
    r.sel = 16'hFFFF;
    r.adr = a;
    r.dat = {4{a ^ 32'hC3C3_0000}};
    return r;
  endfunction

  // driver: apply inputs for one cycle, return at the following negedge
  task automatic step(input logic w, input logic r, input logic [31:0] a, input logic rs);
    bus.wr = w;
    bus.rd = r;
    bus.i  = mk_req(a);
    rst    = rs;
    @(negedge clk);
  endtask

  initial begin
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    bus.i  = '0;
    rst    = 1'b1;
    @(negedge clk);

    // reset then idle
    step(0, 0, 32'h0, 1);
    chk_en = 1'b1;
    step(0, 0, 32'h0, 1);
    step(0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 0);
    chk("rst_count",    W'(bus.count),    W'(0));
    chk("rst_empty",    W'(bus.empty),    W'(1));
    chk("rst_cyc",      W'(bus.o.cyc),    W'(0));
    chk("rst_overflow", W'(bus.overflow), W'(0));

    // fill 0x100..0x10F
    for (int k = 0; k < 16; k++) begin
      step(1, 0, 32'h100 + k, 0);
      chk("fill_count", W'(bus.count),       W'(k + 1));
      chk("fill_afull", W'(bus.almost_full), W'(k + 1 >= 12));
    end
    chk("fill_full", W'(bus.full), W'(1));
    chk("fill_head", W'(bus.o.adr), W'(32'h100));

    // dropped push while full
    step(1, 0, 32'hDEAD, 0);
    chk("ovf_count", W'(bus.count),    W'(16));
    chk("ovf_flag",  W'(bus.overflow), W'(1));

    // simultaneous push/pop while full
    step(1, 1, 32'h1FF, 0);
    chk("fullrw_count", W'(bus.count), W'(16));
    chk("fullrw_head",  W'(bus.o.adr), W'(32'h101));

    // drain: 0x101..0x10F then 0x1FF, never 0xDEAD
    for (int k = 0; k < 16; k++) begin
      chk("drain_adr", W'(bus.o.adr), (k < 15) ? W'(32'h101 + k) : W'(32'h1FF));
      step(0, 1, 32'h0, 0);
    end
    chk("drain_empty", W'(bus.empty),    W'(1));
    chk("drain_ovf",   W'(bus.overflow), W'(1));

    // pop while empty has no effect
    step(0, 1, 32'h0, 0);
    chk("emptypop_count", W'(bus.count), W'(0));

    // simultaneous push/pop while empty
    step(1, 1, 32'h200, 0);
    chk("emptyrw_count", W'(bus.count), W'(1));
    chk("emptyrw_adr",   W'(bus.o.adr), W'(32'h200));
    step(0, 1, 32'h0, 0);
    chk("emptyrw_drain", W'(bus.empty), W'(1));

    // reset clears sticky overflow
    step(0, 0, 32'h0, 1);
    chk("ovf_cleared", W'(bus.overflow), W'(0));

    // wrap-around: random interleaving, occupancy steered through 0..16
    for (int n = 0; n < 40; n++) begin
      logic w;
      logic r;
      if (exp_q.size() < 3)       w = ($urandom_range(0, 3) != 0);
      else if (exp_q.size() > 13) w = ($urandom_range(0, 3) == 0);
      else                        w = $urandom_range(0, 1);
      r = (exp_q.size() > 13) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
      step(w, r, $urandom_range(0, 32'hFFFF) | 32'h0001_0000, 0);
    end
    while (exp_q.size() != 0) step(0, 1, 32'h0, 0);

    // reset mid-operation with count 9 and a push in the reset cycle
    for (int k = 0; k < 9; k++) step(1, 0, 32'h400 + k, 0);
    chk("mid_count9", W'(bus.count), W'(9));
    step(1, 0, 32'h999, 1);
    chk("midrst_count", W'(bus.count), W'(0));
    chk("midrst_empty", W'(bus.empty), W'(1));
    chk("midrst_o",     W'(bus.o),     W'(0));
    step(1, 0, 32'h300, 0);
    chk("post_adr",   W'(bus.o.adr), W'(32'h300));
    chk("post_count", W'(bus.count), W'(1));
    step(0, 1, 32'h0, 0);
    chk("post_empty", W'(bus.empty), W'(1));
    step(0, 0, 32'h0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
